logic_result_fifo: RTL and testbench

//  Downstream buffer for the 8-bit combinational logic unit. Each result byte f is captured

---
 rtl/logic_pkg.sv | 34 +++
 rtl/logic_result_fifo_mem.sv | 26 ++
 rtl/logic_result_fifo.sv | 96 +++++++++
 tb/tb_logic_result_fifo.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/logic_pkg.sv
// Shared types for the logic-unit result FIFO: op encoding and the stored entry layout.
// The entry carries zero/parity bits only when LOGIC_FIFO_STATUS_FLAGS_EN is defined.
package logic_pkg;

    localparam int unsigned DATA_W = 8;

    typedef enum logic [1:0] {
        OP_OR   = 2'b00,
        OP_AND  = 2'b01,
        OP_XOR  = 2'b10,
        OP_NOTX = 2'b11
    } logic_op_e;

    typedef struct packed {
        logic_op_e          op;
        logic [DATA_W-1:0]  data;
`ifdef LOGIC_FIFO_STATUS_FLAGS_EN
        logic               zero;
        logic               parity;
`endif
    } entry_t;

    function automatic entry_t make_entry(input logic [1:0] op, input logic [DATA_W-1:0] data);
        entry_t e;
        e.op     = logic_op_e'(op);
        e.data   = data;
`ifdef LOGIC_FIFO_STATUS_FLAGS_EN
        e.zero   = ~|data;
        e.parity = ^data;
`endif
        return e;
    endfunction

endpackage

// File: rtl/logic_result_fifo_mem.sv
// Unreset register array backing the result FIFO: one synchronous write port and
// one asynchronous read port.
module logic_result_fifo_mem #(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned WIDTH  = 10,
    parameter int unsigned ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [WIDTH-1:0]  wdata_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [WIDTH-1:0]  rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/logic_result_fifo.sv
// Valid/ready FIFO buffering logic-unit results with their op tag.
// Define LOGIC_FIFO_STATUS_FLAGS_EN to store and present per-entry zero/parity flags.
module logic_result_fifo #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned CNT_W  = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [1:0]        in_op,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        out_op,
    output logic [CNT_W-1:0]  count,
    output logic              out_zero,
    output logic              out_parity
);
    import logic_pkg::*;

    localparam int unsigned PtrW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned EntryW = $bits(entry_t);

    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push, pop;
    entry_t           wr_entry, head;

    // Handshakes come only from the registered count, so no input-to-output path exists.
    assign in_ready  = (count_q != CNT_W'(DEPTH));
    assign out_valid = (count_q != '0);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;
    assign count     = count_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = (wr_ptr_q == PtrW'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == PtrW'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign wr_entry = make_entry(in_op, in_data);

    logic_result_fifo_mem #(
        .DEPTH  (DEPTH),
        .WIDTH  (EntryW),
        .ADDR_W (PtrW)
    ) u_mem (
        .clk_i   (clk),
        .we_i    (push),
        .waddr_i (wr_ptr_q),
        .wdata_i (wr_entry),
        .raddr_i (rd_ptr_q),
        .rdata_o (head)
    );

    // Storage is never cleared, so the head is masked while empty.
    assign out_data = out_valid ? head.data : '0;
    assign out_op   = out_valid ? head.op   : 2'b00;

`ifdef LOGIC_FIFO_STATUS_FLAGS_EN
    assign out_zero   = out_valid & head.zero;
    assign out_parity = out_valid & head.parity;
`else
    assign out_zero   = 1'b0;
    assign out_parity = 1'b0;
`endif

endmodule

// File: tb/tb_logic_result_fifo.sv
// Directed bench for logic_result_fifo with a queue scoreboard drained by a monitor.
module tb_logic_result_fifo;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic [1:0] in_op;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic [1:0] out_op;
    logic [2:0] count;
    logic       out_zero;
    logic       out_parity;

    int checks = 0;
    int errors = 0;
    logic [9:0] exp_q[$];

`ifdef LOGIC_FIFO_STATUS_FLAGS_EN
    localparam bit FlagsEn = 1'b1;
`else
    localparam bit FlagsEn = 1'b0;
`endif

    logic_result_fifo dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_op      (in_op),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_op     (out_op),
        .count      (count),
        .out_zero   (out_zero),
        .out_parity (out_parity)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One clock: drive inputs, note acceptance at the negedge, return #1 after the edge.
    task automatic cycle(input logic iv, input logic [1:0] op, input logic [7:0] d,
                         input logic ordy);
        in_valid  = iv;
        in_op     = op;
        in_data   = d;
        out_ready = ordy;
        @(negedge clk);
        if (iv && in_ready) exp_q.push_back({op, d});
        @(posedge clk);
        #1;
    endtask

    // Monitor: every pop is compared against the oldest expected entry.
    always @(negedge clk) begin
        logic [9:0] e;
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_pop", {24'd0, out_data}, 32'hFFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                chk("pop_data", {24'd0, out_data}, {24'd0, e[7:0]});
                chk("pop_op", {30'd0, out_op}, {30'd0, e[9:8]});
                chk("pop_zero", {31'd0, out_zero}, {31'd0, FlagsEn & (e[7:0] == 8'h00)});
                chk("pop_parity", {31'd0, out_parity}, {31'd0, FlagsEn & (^e[7:0])});
            end
        end
    end

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_op = '0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_count", {29'd0, count}, 32'd0);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_out_data", {24'd0, out_data}, 32'h00);
        rst_n = 1'b1;

        // Single pass
        cycle(1'b1, 2'b01, 8'h22, 1'b1);
        chk("single_valid", {31'd0, out_valid}, 32'd1);
        chk("single_data", {24'd0, out_data}, 32'h22);
        chk("single_op", {30'd0, out_op}, 32'd1);
        chk("single_count1", {29'd0, count}, 32'd1);
        cycle(1'b0, 2'b00, 8'h00, 1'b1);
        chk("single_count0", {29'd0, count}, 32'd0);
        chk("empty_valid", {31'd0, out_valid}, 32'd0);
        chk("empty_op", {30'd0, out_op}, 32'd0);

        // Fill, rejected fifth push, ordered drain
        cycle(1'b1, 2'b00, 8'h33, 1'b0);
        cycle(1'b1, 2'b01, 8'hFF, 1'b0);
        cycle(1'b1, 2'b10, 8'h8F, 1'b0);
        cycle(1'b1, 2'b11, 8'h3C, 1'b0);
        chk("full_count", {29'd0, count}, 32'd4);
        chk("full_in_ready", {31'd0, in_ready}, 32'd0);
        cycle(1'b1, 2'b00, 8'h55, 1'b0);
        chk("full_reject_count", {29'd0, count}, 32'd4);
        chk("full_head", {24'd0, out_data}, 32'h33);
        repeat (4) cycle(1'b0, 2'b00, 8'h00, 1'b1);
        chk("drain_count", {29'd0, count}, 32'd0);

        // Full + pop, then steady push&pop across pointer wrap
        cycle(1'b1, 2'b01, 8'h11, 1'b0);
        cycle(1'b1, 2'b10, 8'h22, 1'b0);
        cycle(1'b1, 2'b11, 8'h33, 1'b0);
        cycle(1'b1, 2'b00, 8'h44, 1'b0);
        cycle(1'b1, 2'b10, 8'h55, 1'b1);
        chk("full_pop_count", {29'd0, count}, 32'd3);
        cycle(1'b1, 2'b11, 8'h66, 1'b1);
        chk("pushpop_count", {29'd0, count}, 32'd3);
        for (int i = 0; i < 10; i++) begin
            cycle(1'b1, 2'(i), 8'(8'h10 + i), 1'b1);
            chk("wrap_count", {29'd0, count}, 32'd3);
        end
        repeat (3) cycle(1'b0, 2'b00, 8'h00, 1'b1);
        chk("wrap_drain_count", {29'd0, count}, 32'd0);

        // Mid-stream reset pulse between edges
        cycle(1'b1, 2'b00, 8'h01, 1'b0);
        cycle(1'b1, 2'b01, 8'h02, 1'b0);
        chk("pre_rst_count", {29'd0, count}, 32'd2);
        in_valid = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", {31'd0, out_valid}, 32'd0);
        chk("mid_rst_count", {29'd0, count}, 32'd0);
        exp_q.delete();
        #1 rst_n = 1'b1;
        cycle(1'b1, 2'b10, 8'hA5, 1'b1);
        chk("post_rst_data", {24'd0, out_data}, 32'hA5);
        chk("post_rst_count", {29'd0, count}, 32'd1);
        cycle(1'b0, 2'b00, 8'h00, 1'b1);

        // Status flags
        cycle(1'b1, 2'b00, 8'h00, 1'b0);
        chk("flag_zero_00", {31'd0, out_zero}, {31'd0, FlagsEn});
        chk("flag_par_00", {31'd0, out_parity}, 32'd0);
        cycle(1'b1, 2'b10, 8'h07, 1'b0);
        cycle(1'b0, 2'b00, 8'h00, 1'b1);
        chk("flag_zero_07", {31'd0, out_zero}, 32'd0);
        chk("flag_par_07", {31'd0, out_parity}, {31'd0, FlagsEn});
        cycle(1'b0, 2'b00, 8'h00, 1'b1);
        chk("final_count", {29'd0, count}, 32'd0);
        chk("empty_flags", {30'd0, out_zero, out_parity}, 32'd0);
        chk("scoreboard_empty", exp_q.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
